// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory fetch bus between the fetch unit and instruction memory.
//   imem_req   : fetch request, held high until imem_ack
//   imem_addr  : fetch address, stable while imem_req is high
//   imem_ack   : one-cycle acknowledge, imem_rdata valid in the same cycle
//   imem_rdata : instruction word returned by memory
// Modports: master = fetch unit side, slave = memory side.
// -----------------------------------------------------------------------------
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Owns the program counter, fetches instruction words over a req/ack bus and
// presents each word to a single-cycle core for one or more EXEC cycles.
// Ports:
//   i_clk, i_rst_n  : rising-edge clock, asynchronous active-low reset
//   imem            : instruction-memory bus (master side)
//   o_instr         : registered instruction word
//   o_instr_valid   : o_instr is executing this cycle
//   o_pc            : current PC
//   o_pc_plus4      : o_pc + 4 (combinational)
//   i_pc_next_c     : {jr, j, branch} select from the controller
//   i_imm_ext       : extended immediate for branches
//   i_jr_addr       : register value for jr
//   i_stall         : hold the current instruction, no PC update
//   i_halt          : stop after the current instruction
//   o_halted        : unit is halted
//   o_fetch_err     : sticky fetch timeout / misaligned jr target
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    fetch_unit_if.master      imem,
    output logic [31:0]       o_instr,
    output logic              o_instr_valid,
    output logic [31:0]       o_pc,
    output logic [31:0]       o_pc_plus4,
    input  logic [2:0]        i_pc_next_c,
    input  logic [31:0]       i_imm_ext,
    input  logic [31:0]       i_jr_addr,
    input  logic              i_stall,
    input  logic              i_halt,
    output logic              o_halted,
    output logic              o_fetch_err
);

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [15:0] r_cnt;
    logic        r_err;
    // Low from reset until the first clock edge after release, so no request
    // is issued (and no ack accepted) in the cycle rst_n rises.
    logic        r_active;

    logic        w_req;
    logic        w_valid;
    logic        w_halted;
    logic        w_load_instr;
    logic        w_pc_load;
    logic        w_cnt_clr;
    logic        w_cnt_inc;
    logic        w_set_err;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_imm_sh;
    logic [31:0] w_next_pc;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_imm_sh   = i_imm_ext << 2;

    // Next-PC select: jr > j > branch > sequential.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (i_pc_next_c[2]) begin
            w_next_pc = {i_jr_addr[31:2], 2'b00};
        end else if (i_pc_next_c[1]) begin
            w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
        end else if (i_pc_next_c[0]) begin
            w_next_pc = w_pc_plus4 + w_imm_sh;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_valid      = 1'b0;
        w_halted     = 1'b0;
        w_load_instr = 1'b0;
        w_pc_load    = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_req = r_active;
                if (r_active) begin
                    if (imem.imem_ack) begin
                        w_load_instr = 1'b1;
                        w_cnt_clr    = 1'b1;
                        w_state_next = ST_EXEC;
                    end else if (r_cnt == TMO_LAST) begin
                        w_set_err    = 1'b1;
                        w_cnt_clr    = 1'b1;
                        w_state_next = ST_HALTED;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                w_valid = 1'b1;
                if (!i_stall) begin
                    w_pc_load = 1'b1;
                    if (i_pc_next_c[2] && (i_jr_addr[1:0] != 2'b00)) begin
                        w_set_err = 1'b1;
                    end
                    w_state_next = i_halt ? ST_HALTED : ST_FETCH;
                end
            end
            ST_HALTED: begin
                w_halted = 1'b1;
                if (!r_err && !i_halt) begin
                    w_state_next = ST_FETCH;
                end
            end
            default: begin
                w_state_next = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc     <= RESET_PC;
            r_instr  <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
            if (w_load_instr) begin
                r_instr <= imem.imem_rdata;
            end
            if (w_pc_load) begin
                r_pc <= w_next_pc;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;
    assign o_instr        = r_instr;
    assign o_instr_valid  = w_valid;
    assign o_pc           = r_pc;
    assign o_pc_plus4     = w_pc_plus4;
    assign o_halted       = w_halted;
    assign o_fetch_err    = r_err;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// instruction stream, compared against an instruction-level reference model
// (expected PC / instruction / error flag computed from the next-PC rules).
// A second instance with TIMEOUT = 4 and no memory response covers timeout.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rst_t_n;

    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [2:0]  pc_next_c;
    logic [31:0] imm_ext;
    logic [31:0] jr_addr;
    logic        stall;
    logic        halt;
    logic        halted;
    logic        fetch_err;

    logic [31:0] t_instr;
    logic        t_instr_valid;
    logic [31:0] t_pc;
    logic [31:0] t_pc_plus4;
    logic        t_halted;
    logic        t_fetch_err;

    fetch_unit_if u_if ();
    fetch_unit_if u_if_t ();

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (255)
    ) u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .imem          (u_if.master),
        .o_instr       (instr),
        .o_instr_valid (instr_valid),
        .o_pc          (pc),
        .o_pc_plus4    (pc_plus4),
        .i_pc_next_c   (pc_next_c),
        .i_imm_ext     (imm_ext),
        .i_jr_addr     (jr_addr),
        .i_stall       (stall),
        .i_halt        (halt),
        .o_halted      (halted),
        .o_fetch_err   (fetch_err)
    );

    fetch_unit #(
        .RESET_PC (32'h0000_0100),
        .TIMEOUT  (4)
    ) u_dut_tmo (
        .i_clk         (clk),
        .i_rst_n       (rst_t_n),
        .imem          (u_if_t.master),
        .o_instr       (t_instr),
        .o_instr_valid (t_instr_valid),
        .o_pc          (t_pc),
        .o_pc_plus4    (t_pc_plus4),
        .i_pc_next_c   (3'b000),
        .i_imm_ext     (32'h0000_0000),
        .i_jr_addr     (32'h0000_0000),
        .i_stall       (1'b0),
        .i_halt        (1'b0),
        .o_halted      (t_halted),
        .o_fetch_err   (t_fetch_err)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model state: committed PC, instruction in flight, sticky error.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] cur_pc, input logic [31:0] cur_instr,
                                             input logic [2:0] sel, input logic [31:0] imm,
                                             input logic [31:0] jr);
        logic [31:0] p4;
        p4 = cur_pc + 32'd4;
        if (sel[2]) return jr - (jr % 32'd4);
        if (sel[1]) return (p4 & 32'hF000_0000) + (cur_instr % 32'h0400_0000) * 32'd4;
        if (sel[0]) return p4 + imm * 32'd4;
        return p4;
    endfunction

    // Called at a negedge while the DUT is fetching; ack after 'delay' cycles.
    task automatic do_fetch(input int delay, input logic [31:0] word);
        check_val("fetch_req", 32'(u_if.imem_req), 32'd1);
        check_val("fetch_addr", u_if.imem_addr, m_pc);
        check_val("fetch_novalid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check_val("wait_req", 32'(u_if.imem_req), 32'd1);
            check_val("wait_addr", u_if.imem_addr, m_pc);
        end
        u_if.imem_ack   = 1'b1;
        u_if.imem_rdata = word;
        @(negedge clk);
        u_if.imem_ack   = 1'b0;
        u_if.imem_rdata = $urandom;
        m_instr = word;
        check_val("exec_valid", 32'(instr_valid), 32'd1);
        check_val("exec_instr", instr, m_instr);
        check_val("exec_pc", pc, m_pc);
        check_val("exec_noreq", 32'(u_if.imem_req), 32'd0);
    endtask

    // Called at a negedge in EXEC; stalls, then commits the next PC.
    task automatic do_exec(input int stalls, input logic [2:0] sel, input logic [31:0] imm,
                           input logic [31:0] jr, input logic hlt);
        for (int i = 0; i < stalls; i++) begin
            stall           = 1'b1;
            pc_next_c       = 3'($urandom);
            u_if.imem_ack   = 1'($urandom);
            u_if.imem_rdata = $urandom;
            @(negedge clk);
            check_val("stall_valid", 32'(instr_valid), 32'd1);
            check_val("stall_pc", pc, m_pc);
            check_val("stall_instr", instr, m_instr);
        end
        u_if.imem_ack = 1'b0;
        stall     = 1'b0;
        pc_next_c = sel;
        imm_ext   = imm;
        jr_addr   = jr;
        halt      = hlt;
        m_pc = ref_next(m_pc, m_instr, sel, imm, jr);
        if (sel[2] && (jr % 32'd4 != 32'd0)) m_err = 1'b1;
        @(negedge clk);
        pc_next_c = 3'b000;
        check_val("commit_pc", pc, m_pc);
        check_val("commit_plus4", pc_plus4, m_pc + 32'd4);
        check_val("commit_novalid", 32'(instr_valid), 32'd0);
        check_val("commit_halted", 32'(halted), 32'(hlt));
        check_val("commit_err", 32'(fetch_err), 32'(m_err));
    endtask

    // Called at a negedge in HALTED; stays for 'cycles', then releases halt.
    task automatic do_halt_hold(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            u_if.imem_ack = 1'($urandom);
            @(negedge clk);
            check_val("halt_hold", 32'(halted), 32'd1);
            check_val("halt_noreq", 32'(u_if.imem_req), 32'd0);
            check_val("halt_pc", pc, m_pc);
        end
        u_if.imem_ack = 1'b0;
        halt = 1'b0;
        @(negedge clk);
        check_val("resume_halted", 32'(halted), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          d;
        int          st;
        logic [2:0]  sel;
        logic        h;

        rst_n             = 1'b0;
        rst_t_n           = 1'b0;
        pc_next_c         = 3'b000;
        imm_ext           = '0;
        jr_addr           = '0;
        stall             = 1'b0;
        halt              = 1'b0;
        u_if.imem_ack     = 1'b0;
        u_if.imem_rdata   = '0;
        u_if_t.imem_ack   = 1'b0;
        u_if_t.imem_rdata = '0;
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_err   = 1'b0;

        #1;
        check_val("rst_req", 32'(u_if.imem_req), 32'd0);
        check_val("rst_valid", 32'(instr_valid), 32'd0);
        check_val("rst_halted", 32'(halted), 32'd0);
        check_val("rst_err", 32'(fetch_err), 32'd0);
        check_val("rst_pc", pc, 32'h0);
        check_val("rst_instr", instr, 32'h0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_val("rel_req", 32'(u_if.imem_req), 32'd0);
        @(negedge clk);

        // Sequential run, ack one cycle after each request.
        for (int k = 0; k < 4; k++) begin
            do_fetch(1, 32'hA000_0000 + 32'(k));
            do_exec(0, 3'b000, '0, '0, 1'b0);
        end
        check_val("seq_pc", pc, 32'h0000_0010);

        // Branch backwards from 0x10.
        do_fetch(0, $urandom);
        do_exec(0, 3'b001, 32'hFFFF_FFFE, $urandom, 1'b0);
        check_val("branch_pc", pc, 32'h0000_000C);

        // jr to 0x1000_0000, then j with instr[25:0] = 0x40.
        do_fetch(0, $urandom);
        do_exec(0, 3'b100, $urandom, 32'h1000_0000, 1'b0);
        do_fetch(0, 32'h0800_0040);
        do_exec(0, 3'b010, $urandom, $urandom, 1'b0);
        check_val("jump_pc", pc, 32'h1000_0100);

        // All select bits set: jr wins.
        do_fetch(0, $urandom);
        do_exec(0, 3'b111, $urandom, 32'h0000_0200, 1'b0);
        check_val("prio_pc", pc, 32'h0000_0200);

        // Ack delayed five cycles, then three stall cycles.
        do_fetch(5, $urandom);
        do_exec(3, 3'b000, '0, '0, 1'b0);
        check_val("stall_commit", pc, 32'h0000_0204);

        // Halt from EXEC, then resume.
        do_fetch(0, $urandom);
        do_exec(0, 3'b000, '0, '0, 1'b1);
        check_val("halt_pc_c", pc, 32'h0000_0208);
        do_halt_hold(3);

        // Halt raised during FETCH: fetch and execute complete first.
        halt = 1'b1;
        do_fetch(2, $urandom);
        do_exec(0, 3'b000, '0, '0, 1'b1);
        do_halt_hold(1);

        // Randomized stream with aligned jr targets.
        for (int n = 0; n < 40; n++) begin
            d   = int'($urandom_range(0, 3));
            st  = int'($urandom_range(0, 2));
            sel = 3'($urandom);
            h   = ($urandom_range(0, 7) == 0);
            do_fetch(d, $urandom);
            do_exec(st, sel, $urandom, $urandom & 32'hFFFF_FFFC, h);
            if (h) do_halt_hold(int'($urandom_range(0, 2)));
        end

        // Wrap: 0xFFFF_FFFC + 4 = 0.
        do_fetch(0, $urandom);
        do_exec(0, 3'b100, '0, 32'hFFFF_FFFC, 1'b0);
        do_fetch(0, $urandom);
        do_exec(0, 3'b000, '0, '0, 1'b0);
        check_val("wrap_pc", pc, 32'h0000_0000);

        // Misaligned jr target.
        do_fetch(0, $urandom);
        do_exec(0, 3'b100, '0, 32'h0000_0203, 1'b0);
        check_val("misalign_pc", pc, 32'h0000_0200);
        check_val("misalign_err", 32'(fetch_err), 32'd1);

        // Asynchronous reset in the middle of a fetch.
        check_val("pre_rst_req", 32'(u_if.imem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_req", 32'(u_if.imem_req), 32'd0);
        check_val("arst_valid", 32'(instr_valid), 32'd0);
        check_val("arst_pc", pc, 32'h0);
        check_val("arst_err", 32'(fetch_err), 32'd0);
        @(negedge clk);
        rst_n           = 1'b1;
        u_if.imem_ack   = 1'b1;
        u_if.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        u_if.imem_ack = 1'b0;
        check_val("rel_ack_ignored", 32'(instr_valid), 32'd0);
        m_pc  = 32'h0;
        m_err = 1'b0;
        do_fetch(0, 32'h1234_5678);
        do_exec(0, 3'b000, '0, '0, 1'b0);

        // Timeout instance: TIMEOUT = 4, memory never answers.
        rst_t_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check_val("tmo_req", 32'(u_if_t.imem_req), 32'd1);
            check_val("tmo_nohalt", 32'(t_halted), 32'd0);
            check_val("tmo_addr", u_if_t.imem_addr, 32'h0000_0100);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_val("tmo_halted", 32'(t_halted), 32'd1);
            check_val("tmo_err", 32'(t_fetch_err), 32'd1);
            check_val("tmo_noreq", 32'(u_if_t.imem_req), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Owns the program counter and fetches instruction words from instruction memory over a req/ack handshake.
- Presents each fetched word to the single-cycle core, where the controller decodes op_c/funct.
- Consumes the controller's 3-bit next-PC select to pick the following PC.
- Replaces the free-running PC register so instruction memory may have variable latency.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 255, max cycles in FETCH without imem_ack before fetch_err (1..65535)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request, held high until imem_ack
imem_addr  output  32  fetch address (= pc), stable while imem_req high
imem_ack  input  1  one-cycle acknowledge; imem_rdata valid in the same cycle
imem_rdata  input  32  instruction word
instr  output  32  registered instruction to core (op_c = instr[31:26], funct = instr[5:0])
instr_valid  output  1  instr is executing this cycle
pc  output  32  current PC
pc_plus4  output  32  pc + 4, combinational
pc_next_c  input  3  {jr_c, j_c, branch_c} from controller, sampled in EXEC
imm_ext  input  32  extended immediate from datapath
jr_addr  input  32  register-file value for jr
stall  input  1  hold current instruction; no PC update
halt  input  1  request to stop after the current instruction
halted  output  1  unit is in HALTED
fetch_err  output  1  sticky: fetch timeout or misaligned jr target

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc = RESET_PC; instr = 32'h0000_0000; state = FETCH.
  - imem_req = 0, instr_valid = 0, halted = 0, fetch_err = 0; timeout counter = 0.
  - imem_req first goes high in the first cycle after rst_n rises.
- Reset mid-fetch abandons the outstanding request. imem_ack arriving in the cycle rst_n rises is ignored.
- States: FETCH, EXEC, HALTED.
- FETCH:
  - imem_req = 1, imem_addr = pc.
  - On imem_ack: instr <= imem_rdata, counter <= 0, go EXEC.
  - Otherwise counter increments. When counter reaches TIMEOUT-1 without ack: fetch_err <= 1, go HALTED.
  - halt and stall are ignored in FETCH; a started fetch always completes.
- EXEC:
  - instr_valid = 1, imem_req = 0.
  - stall = 1: remain in EXEC; pc and instr unchanged; instr_valid stays 1.
  - stall = 0: pc <= next_pc. Go HALTED if halt = 1, else FETCH.
- Best-case throughput is one instruction per 2 cycles (ack in first FETCH cycle).
- next_pc, by priority jr > j > branch > sequential:
  - pc_next_c[2] (jr): {jr_addr[31:2], 2'b00}. If jr_addr[1:0] != 0, fetch_err <= 1 and the aligned value is still used.
  - pc_next_c[1] (j): {pc_plus4[31:28], instr[25:0], 2'b00}.
  - pc_next_c[0] (branch): pc_plus4 + {imm_ext[29:0], 2'b00}, modulo 2^32.
  - 3'b000: pc_plus4.
  - Multiple bits set: the highest priority wins, no error.
- PC arithmetic wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- HALTED:
  - halted = 1, imem_req = 0, instr_valid = 0.
  - If fetch_err = 0 and halt = 0: go FETCH next cycle at the committed pc.
  - If fetch_err = 1: remain in HALTED until reset.
- fetch_err clears only on reset.
- imem_ack outside FETCH is ignored.

Test Plan:
1. Sequential run: RESET_PC = 0, ack 1 cycle after each req, pc_next_c = 0 -> imem_addr sequence 0, 4, 8, 12; instr_valid pulses one cycle per instruction; instr equals each returned word.
2. Branch/jump/jr:
   - Branch: pc = 0x10, branch_c = 1, imm_ext = 0xFFFF_FFFE -> next pc 0x0C.
   - Jump: pc = 0x1000_0000, instr[25:0] = 0x40 -> next pc 0x1000_0100.
   - jr: jr_addr = 0x200 -> next pc 0x200.
   - pc_next_c = 3'b111 -> next pc = jr_addr.
3. Stall and latency:
   - Assert stall 3 cycles in EXEC -> pc unchanged, instr_valid high 4 cycles total, a single PC update after release.
   - Ack delayed 5 cycles -> imem_req and imem_addr held stable for all 6 cycles.
4. Halt:
   - halt with stall = 0 at pc = 0x8 -> pc becomes 0xC, halted = 1, no imem_req while halt is high.
   - Deassert halt -> fetch resumes at 0xC.
   - halt during FETCH -> fetch completes, instruction executes, then HALTED.
5. Errors:
   - TIMEOUT = 4, no ack -> fetch_err = 1 and halted = 1 after 4 FETCH cycles; both stay high with halt = 0.
   - jr_addr = 0x203 -> pc = 0x200, fetch_err = 1.
6. Async reset: drop rst_n mid-FETCH (between clock edges) -> imem_req and instr_valid go low at once, pc = RESET_PC; after release, fetch restarts at RESET_PC; wrap check 0xFFFF_FFFC -> 0.
